// File: rtl/mem_a_tile_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : mem_a_tile_fetcher
//  Description : Pops row addresses from the A-address FIFO, issues one
//                single-beat read per address to memory A and gathers
//                ARRAY_HEIGHT returned words into one tile (row 0 = LSBs).
//                The finished tile is offered to the array-feed stage with a
//                valid/ready handshake; only one tile buffer exists, so the
//                next fill starts after the current tile is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_a_tile_fetcher #(
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ARRAY_HEIGHT     = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [15:0]                               a_fifo_addr,
    input  logic                                      a_fifo_empty,
    output logic                                      a_fifo_pop,
    output logic                                      mem_rd_en,
    output logic [15:0]                               mem_rd_addr,
    input  logic [BUS_WIDTH_BYTES*8-1:0]              mem_rd_data,
    input  logic                                      mem_rd_valid,
    output logic [ARRAY_HEIGHT*BUS_WIDTH_BYTES*8-1:0] tile_data,
    output logic                                      tile_valid,
    input  logic                                      tile_ready,
    output logic                                      rd_err
);

    localparam int c_WORD_W = BUS_WIDTH_BYTES * 8;
    localparam int c_CNT_W  = $clog2(ARRAY_HEIGHT) + 1;

    localparam logic [c_CNT_W-1:0] c_H    = c_CNT_W'(ARRAY_HEIGHT);
    localparam logic [c_CNT_W-1:0] c_H_M1 = c_CNT_W'(ARRAY_HEIGHT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_FILL    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_PRESENT = 2'd2;

    // Reject parameter sets the row indexing cannot represent.
    generate
        if (ARRAY_HEIGHT < 2 || (ARRAY_HEIGHT & (ARRAY_HEIGHT - 1)) != 0 ||
            DATA_WIDTH_BYTES < 1 || (BUS_WIDTH_BYTES % DATA_WIDTH_BYTES) != 0) begin : g_bad_params
            $error("mem_a_tile_fetcher: unsupported parameter combination");
        end
    endgenerate

    logic [1:0]                               r_state;
    logic [1:0]                               w_state_nxt;
    logic [c_CNT_W-1:0]                       r_issued;
    logic [c_CNT_W-1:0]                       r_returned;
    logic                                     r_rd_en;
    logic [15:0]                              r_rd_addr;
    logic [ARRAY_HEIGHT*c_WORD_W-1:0]         r_tile_data;
    logic                                     r_tile_valid;
    logic                                     r_rd_err;
    logic                                     w_pop;
    logic                                     w_accept;
    logic                                     w_ret_ok;
    logic                                     w_ret_bad;

    // A return beat is only legal while collecting and with a read in flight.
    assign w_ret_ok  = mem_rd_valid & (r_state != c_ST_PRESENT) & (r_returned < r_issued);
    assign w_ret_bad = mem_rd_valid & ~w_ret_ok;

    // Next-state and pop decode; pop is masked during reset so no FIFO entry is lost.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            c_ST_FILL: begin
                w_pop = ~reset & ~a_fifo_empty & (r_issued < c_H);
                if (w_pop && (r_issued == c_H_M1)) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_returned == c_H) begin
                    w_state_nxt = c_ST_PRESENT;
                end
            end
            c_ST_PRESENT: begin
                if (r_tile_valid && tile_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_ST_FILL;
                end
            end
            default: begin
                w_state_nxt = c_ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue/return counters; both clear when the tile is handed off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issued   <= '0;
            r_returned <= '0;
        end else if (w_accept) begin
            r_issued   <= '0;
            r_returned <= '0;
        end else begin
            if (w_pop) begin
                r_issued <= r_issued + c_ONE;
            end
            if (w_ret_ok) begin
                r_returned <= r_returned + c_ONE;
            end
        end
    end

    // Read request is the popped head address, one cycle later; address holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_pop;
            if (w_pop) begin
                r_rd_addr <= a_fifo_addr;
            end
        end
    end

    // Land each accepted return word in the row slot given by the return count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tile_data <= '0;
        end else begin
            for (int r = 0; r < ARRAY_HEIGHT; r++) begin
                if (w_ret_ok && (r_returned == c_CNT_W'(r))) begin
                    r_tile_data[r*c_WORD_W +: c_WORD_W] <= mem_rd_data;
                end
            end
        end
    end

    // Tile valid rises on entry to PRESENT and falls only on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tile_valid <= 1'b0;
        end else if ((r_state == c_ST_WAIT) && (w_state_nxt == c_ST_PRESENT)) begin
            r_tile_valid <= 1'b1;
        end else if (w_accept) begin
            r_tile_valid <= 1'b0;
        end
    end

    // Sticky flag for return beats that have no matching outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_err <= 1'b0;
        end else if (w_ret_bad) begin
            r_rd_err <= 1'b1;
        end
    end

    assign a_fifo_pop  = w_pop;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign tile_data   = r_tile_data;
    assign tile_valid  = r_tile_valid;
    assign rd_err      = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_a_tile_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_a_tile_fetcher
//  Description : Directed bench for mem_a_tile_fetcher with a FIFO/memory
//                stub, a transaction-level reference model and literal pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_a_tile_fetcher;

    localparam int H = 4;
    localparam int W = 256;

    logic             clk;
    logic             reset;
    logic [15:0]      a_fifo_addr;
    logic             a_fifo_empty;
    logic             a_fifo_pop;
    logic             mem_rd_en;
    logic [15:0]      mem_rd_addr;
    logic [W-1:0]     mem_rd_data;
    logic             mem_rd_valid;
    logic [H*W-1:0]   tile_data;
    logic             tile_valid;
    logic             tile_ready;
    logic             rd_err;

    mem_a_tile_fetcher #(
        .BUS_WIDTH_BYTES (32),
        .DATA_WIDTH_BYTES(1),
        .ARRAY_HEIGHT    (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_fifo_addr (a_fifo_addr),
        .a_fifo_empty(a_fifo_empty),
        .a_fifo_pop  (a_fifo_pop),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_rd_valid(mem_rd_valid),
        .tile_data   (tile_data),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .rd_err      (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // ---------------- stimulus side: FIFO and memory stubs ----------------
    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    logic [15:0] fq[$];
    rd_t         pend[$];
    int          cyc = 0;
    int          lat = 2;
    logic        rst_q = 1'b1;
    logic        rdy_q = 1'b1;
    logic        spur = 1'b0;
    int          n_pop = 0, n_rden = 0, n_valid = 0, n_ret = 0;
    logic        last_pop;
    logic [H*W-1:0] cap;

    // One clock: drive inputs at negedge, then react to DUT outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        reset      = rst_q;
        tile_ready = rdy_q;
        if (rst_q) pend.delete();
        a_fifo_empty = (fq.size() == 0);
        a_fifo_addr  = (fq.size() != 0) ? fq[0] : 16'h0000;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        if (!rst_q && pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = {16{pend[0].addr}};
            void'(pend.pop_front());
            n_ret++;
        end else if (!rst_q && spur) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = {16{16'hDEAD}};
            spur = 1'b0;
        end
        #1;
        last_pop = a_fifo_pop;
        if (a_fifo_pop) begin
            n_pop++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        if (mem_rd_en && !rst_q) begin
            n_rden++;
            pend.push_back('{mem_rd_addr, cyc + lat});
        end
        if (tile_valid) begin
            n_valid++;
            cap = tile_data;
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push4(logic [15:0] base);
        for (int i = 0; i < H; i++) fq.push_back(base + 16'(16 * i));
    endtask

    task automatic chk_tile(string nm, logic [15:0] base);
        logic [15:0] a;
        for (int r = 0; r < H; r++) begin
            a = base + 16'(16 * r);
            chk(nm, cap[r*W +: W], {16{a}});
        end
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    int          m_req = 0, m_ret = 0;
    logic        m_present = 1'b0, m_err = 1'b0;
    logic        m_en_next = 1'b0;
    logic [15:0] m_addr_next = 16'h0;
    logic [W-1:0] m_tile[H];

    always @(negedge clk) begin
        int   old_req, old_ret;
        logic exp_pop;
        #2;
        if (reset) begin
            chk("rst_valid", tile_valid, 1'b0);
            chk("rst_rd_en", mem_rd_en, 1'b0);
            chk("rst_rd_addr", mem_rd_addr, 16'h0);
            chk("rst_rd_err", rd_err, 1'b0);
            chk("rst_pop", a_fifo_pop, 1'b0);
            for (int r = 0; r < H; r++) chk("rst_tile", tile_data[r*W +: W], '0);
            m_req = 0; m_ret = 0; m_present = 1'b0; m_err = 1'b0; m_en_next = 1'b0;
        end else begin
            chk("tile_valid", tile_valid, m_present);
            if (m_present)
                for (int r = 0; r < H; r++) chk("tile_row", tile_data[r*W +: W], m_tile[r]);
            chk("rd_err", rd_err, m_err);
            chk("rd_en", mem_rd_en, m_en_next);
            if (m_en_next) chk("rd_addr", mem_rd_addr, m_addr_next);
            exp_pop = !a_fifo_empty && !m_present && (m_req < H);
            chk("pop", a_fifo_pop, exp_pop);
            old_req = m_req;
            old_ret = m_ret;
            m_en_next   = exp_pop;
            m_addr_next = a_fifo_addr;
            if (exp_pop) m_req++;
            if (mem_rd_valid) begin
                if (!m_present && old_ret < old_req) begin
                    m_tile[old_ret] = mem_rd_data;
                    m_ret++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_present) begin
                if (tile_ready) begin
                    m_present = 1'b0; m_req = 0; m_ret = 0;
                end
            end else if (old_ret == H) begin
                m_present = 1'b1;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int p0;
        logic got;
        reset = 1'b1; tile_ready = 1'b1; a_fifo_empty = 1'b1;
        a_fifo_addr = '0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        ticks(3);
        rst_q = 1'b0;
        tick();

        // 1: basic tile, latency 2
        n_rden = 0; n_valid = 0;
        push4(16'h0000);
        ticks(20);
        chk("t1_rden_cnt", 32'(n_rden), 32'd4);
        chk("t1_valid_cnt", 32'(n_valid), 32'd1);
        chk_tile("t1_row", 16'h0000);

        // 2: FIFO runs dry after two pops
        n_valid = 0; n_pop = 0;
        fq.push_back(16'h0100); fq.push_back(16'h0110);
        for (int i = 0; i < 10 && n_pop < 2; i++) tick();
        ticks(5);
        chk("t2_pops_while_empty", 32'(n_pop), 32'd2);
        fq.push_back(16'h0120); fq.push_back(16'h0130);
        ticks(15);
        chk("t2_valid_cnt", 32'(n_valid), 32'd1);
        chk_tile("t2_row", 16'h0100);

        // 3: back-pressure with FIFO non-empty
        rdy_q = 1'b0; n_valid = 0;
        push4(16'h0200); push4(16'h0300);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = tile_valid;
        end
        chk("t3_tile_arrives", got, 1'b1);
        p0 = n_pop;
        ticks(10);
        chk("t3_no_pop_held", 32'(n_pop - p0), 32'd0);
        chk_tile("t3_row", 16'h0200);
        rdy_q = 1'b1;
        tick();
        tick();
        chk("t3_fill_resumes", last_pop, 1'b1);
        chk("t3_valid_cnt", 32'(n_valid), 32'd12);
        ticks(15);
        chk_tile("t3_row2", 16'h0300);

        // 4: spurious return beat mid-tile
        n_valid = 0;
        fq.push_back(16'h0400); fq.push_back(16'h0410);
        ticks(8);
        spur = 1'b1;
        ticks(2);
        chk("t4_rd_err", rd_err, 1'b1);
        fq.push_back(16'h0420); fq.push_back(16'h0430);
        ticks(15);
        chk("t4_valid_cnt", 32'(n_valid), 32'd1);
        chk_tile("t4_row", 16'h0400);
        chk("t4_rd_err_sticky", rd_err, 1'b1);

        // 5: latency 1, three tiles back to back
        lat = 1; n_valid = 0;
        push4(16'h0500); push4(16'h0540); push4(16'h0580);
        ticks(40);
        chk("t5_valid_cnt", 32'(n_valid), 32'd3);
        chk_tile("t5_row", 16'h0580);

        // 6: reset after two returns
        lat = 2; n_ret = 0;
        push4(16'h0600);
        for (int i = 0; i < 20 && n_ret < 2; i++) tick();
        rst_q = 1'b1;
        tick();
        chk("t6_valid0", tile_valid, 1'b0);
        chk("t6_err0", rd_err, 1'b0);
        chk("t6_row0_clr", tile_data[0 +: W], '0);
        chk("t6_row1_clr", tile_data[W +: W], '0);
        rst_q = 1'b0;
        fq.delete();
        n_valid = 0;
        push4(16'h0700);
        ticks(15);
        chk("t6_valid_cnt", 32'(n_valid), 32'd1);
        chk_tile("t6_row", 16'h0700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
